apb_master: RTL and testbench

Bridges the core's single-outstanding load/store port onto the APB bus that feeds the address decoder and its peripherals (SRAM, UART, timer, INTC, system ROM). Generates the SETUP/ACCESS phases, byte strobes and lane-replicated write data; extracts and extends load data; converts decoder errors, misalignment and stalled slaves into a single fault response.

---
 rtl/apb_master_if.sv | 35 +++
 rtl/apb_master.sv | 152 +++++++++++++++
 tb/tb_apb_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// apb_master_if: core load/store request port together with the APB bus driven by the bridge.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic                  busy;
    logic                  ack;
    logic                  fault;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic [3:0]            pstb;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perr;

    modport master (
        input  req, req_addr, req_wdata, req_write, req_size, req_signed, prdata, pready, perr,
        output busy, ack, fault, rdata, paddr, pdata, pstb, psel, penable, pwrite
    );

    modport slave (
        output req, req_addr, req_wdata, req_write, req_size, req_signed, prdata, pready, perr,
        input  busy, ack, fault, rdata, paddr, pdata, pstb, psel, penable, pwrite
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: bridges a single-outstanding load/store port onto APB, with lane steering,
// load extension and a single fault response for bus errors, misalignment and stalled slaves.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic          pclk,
    input logic          reset,
    apb_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;

    logic        mis;
    logic [3:0]  stb;
    logic [31:0] wrep;
    logic [31:0] shifted;
    logic [15:0] lane_h;
    logic [31:0] ext;

    assign mis = (bus.req_size == 2'd3) |
                 ((bus.req_size == 2'd1) & bus.req_addr[0]) |
                 ((bus.req_size == 2'd2) & (|bus.req_addr[1:0]));
    assign stb = (bus.req_size == 2'd0) ? (4'b0001 << bus.req_addr[1:0]) :
                 (bus.req_size == 2'd1) ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wrep = (bus.req_size == 2'd0) ? {4{bus.req_wdata[7:0]}} :
                  (bus.req_size == 2'd1) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    // Load lanes come from the address latched on paddr for the current transfer
    assign shifted = bus.prdata >> {paddr_q[1:0], 3'b000};
    assign lane_h  = paddr_q[1] ? bus.prdata[31:16] : bus.prdata[15:0];
    assign ext = (size_q == 2'd0) ? {{24{sgn_q & shifted[7]}}, shifted[7:0]} :
                 (size_q == 2'd1) ? {{16{sgn_q & lane_h[15]}}, lane_h} : bus.prdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        paddr_d   = paddr_q;
        pdata_d   = pdata_q;
        pstb_d    = pstb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        case (state_q)
            IDLE: if (bus.req) begin
                busy_d = 1'b1;
                size_d = bus.req_size;
                sgn_d  = bus.req_signed;
                cnt_d  = '0;
                if (mis) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pdata_d  = wrep;
                    pstb_d   = bus.req_write ? stb : 4'b0000;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: if (bus.pready || cnt_q == CW'(TIMEOUT - 1)) begin
                state_d   = DONE;
                ack_d     = 1'b1;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                fault_d   = bus.pready ? bus.perr : 1'b1;
                rdata_d   = (bus.pready && !bus.perr && !pwrite_q) ? ext : '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            size_q    <= 2'd0;
            sgn_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
            paddr_q   <= '0;
            pdata_q   <= '0;
            pstb_q    <= 4'b0000;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            pstb_q    <= pstb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.ack     = ack_q;
    assign bus.fault   = fault_q;
    assign bus.rdata   = rdata_q;
    assign bus.paddr   = paddr_q;
    assign bus.pdata   = pdata_q;
    assign bus.pstb    = pstb_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table of load/store transfers against a responsive APB slave model,
// with a scoreboard of expected completions and hand sequences for reset, hold and busy cases.
module tb_apb_master;
    logic pclk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ack = 0;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        perr;
        logic        has_bus;
        logic        fault;
        logic [31:0] rdata;
        logic [3:0]  pstb;
        logic [31:0] pdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endfunction

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] prdata, int waits, logic perr,
                                logic has_bus, logic fault, logic [31:0] rdata, logic [3:0] pstb,
                                logic [31:0] pdata, int lat);
        vec_t v;
        v = '{wr, sz, sg, addr, wdata, prdata, waits, perr, has_bus, fault, rdata, pstb, pdata, lat};
        return v;
    endfunction

    // Scoreboard: every ack retires the oldest expected completion
    always @(negedge pclk) begin
        if (!reset && bus.ack) begin
            exp_t e;
            n_ack++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1, want no ack");
            end else begin
                e = exp_q.pop_front();
                chk("ack_fault", 32'(bus.fault), 32'(e.fault));
                chk("ack_rdata", bus.rdata, e.rdata);
                chk("ack_latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("psel_with_ack", 32'(bus.psel), 32'd0);
            end
        end
    end

    task automatic run(input vec_t v, input bit poke);
        int  t0, acc, a0;
        bit  seen, done;
        a0 = n_ack;
        @(negedge pclk);
        bus.req        = 1'b1;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_write  = v.wr;
        bus.req_size   = v.sz;
        bus.req_signed = v.sg;
        bus.prdata     = v.prdata;
        bus.perr       = v.perr;
        bus.pready     = 1'b0;
        t0 = cyc;
        exp_q.push_back('{v.fault, v.rdata, v.lat, t0});
        acc  = 0;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge pclk);
            if (poke) bus.req_addr = 32'h6000_0000;
            else bus.req = 1'b0;
            if (bus.ack) begin
                done    = 1'b1;
                bus.req = 1'b0;
            end
            if (bus.psel && !bus.penable && !seen) begin
                seen = 1'b1;
                chk("setup_cycle", 32'(cyc - t0), 32'd1);
                chk("paddr", bus.paddr, v.addr);
                chk("pwrite", 32'(bus.pwrite), 32'(v.wr));
                chk("pstb", 32'(bus.pstb), 32'(v.pstb));
                if (v.wr) chk("pdata", bus.pdata, v.pdata);
            end
            if (bus.psel && bus.penable) acc++;
            bus.pready = bus.psel && bus.penable && (acc > v.waits);
        end
        bus.pready = 1'b0;
        chk("bus_cycle_seen", 32'(seen), 32'(v.has_bus));
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_wait: got no ack in 30 cycles, want ack");
            void'(exp_q.pop_back());
        end
        if (poke) begin
            @(negedge pclk);
            chk("poke_busy_after", 32'(bus.busy), 32'd0);
            chk("poke_ack_count", 32'(n_ack - a0), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        int   a0;
        reset          = 1'b1;
        bus.req        = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.prdata     = '0;
        bus.pready     = 1'b0;
        bus.perr       = 1'b0;

        //               wr  sz   sg  addr          wdata         prdata        w  perr bus flt  rdata         pstb     pdata        lat
        vecs.push_back(mk(1, 2'd2, 0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 3));
        vecs.push_back(mk(0, 2'd0, 1, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 1, 0, 32'hFFFF_FF80, 4'b0000, 32'h0,        3));
        vecs.push_back(mk(0, 2'd0, 0, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 1, 0, 32'h0000_0080, 4'b0000, 32'h0,        3));
        vecs.push_back(mk(1, 2'd1, 0, 32'h1000_0002, 32'h0000_ABCD, 32'h0,        2, 0, 1, 0, 32'h0,        4'b1100, 32'hABCD_ABCD, 5));
        vecs.push_back(mk(0, 2'd2, 0, 32'h8000_0002, 32'h0,         32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h3000_0000, 32'h0,         32'h1234_5678, 0, 1, 1, 1, 32'h0,        4'b0000, 32'h0,        3));
        vecs.push_back(mk(0, 2'd2, 0, 32'h4000_0000, 32'h0,         32'h1234_5678, 255, 0, 1, 1, 32'h0,      4'b0000, 32'h0,        6));
        vecs.push_back(mk(0, 2'd1, 1, 32'h2000_0002, 32'h0,         32'h8001_7FFF, 1, 0, 1, 0, 32'hFFFF_8001, 4'b0000, 32'h0,        4));
        vecs.push_back(mk(0, 2'd1, 0, 32'h2000_0000, 32'h0,         32'h8001_F00D, 0, 0, 1, 0, 32'h0000_F00D, 4'b0000, 32'h0,        3));
        vecs.push_back(mk(1, 2'd0, 0, 32'h2000_0001, 32'h0000_005A, 32'h0,        0, 0, 1, 0, 32'h0,        4'b0010, 32'h5A5A_5A5A, 3));
        vecs.push_back(mk(0, 2'd0, 1, 32'h2000_0001, 32'h0,         32'h0000_7F00, 0, 0, 1, 0, 32'h0000_007F, 4'b0000, 32'h0,        3));
        vecs.push_back(mk(0, 2'd3, 0, 32'h0000_0000, 32'h0,         32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1));
        vecs.push_back(mk(1, 2'd1, 0, 32'h2000_0001, 32'h0000_1111, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1));
        vecs.push_back(mk(0, 2'd2, 1, 32'h2000_0008, 32'h0,         32'h8000_0000, 0, 0, 1, 0, 32'h8000_0000, 4'b0000, 32'h0,        3));
        vecs.push_back(mk(1, 2'd2, 0, 32'h3000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1, 1, 1, 32'h0,        4'b1111, 32'h1234_5678, 3));
        vecs.push_back(mk(1, 2'd2, 0, 32'h2000_000C, 32'hCAFE_F00D, 32'h0,        3, 0, 1, 0, 32'h0,        4'b1111, 32'hCAFE_F00D, 6));
        vecs.push_back(mk(0, 2'd0, 0, 32'h2000_0002, 32'h0,         32'hAA55_CC33, 0, 1, 1, 1, 32'h0,        4'b0000, 32'h0,        3));

        repeat (3) @(negedge pclk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst_pstb", 32'(bus.pstb), 32'd0);
        chk("rst_paddr", bus.paddr, 32'd0);
        chk("rst_pdata", bus.pdata, 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i], 1'b0);

        // Misaligned request must leave the previous bus address/data untouched
        run(mk(1, 2'd2, 0, 32'h7000_0010, 32'h1122_3344, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 32'h1122_3344, 3), 1'b0);
        run(mk(0, 2'd2, 0, 32'h7000_0011, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 1), 1'b0);
        @(negedge pclk);
        chk("hold_paddr", bus.paddr, 32'h7000_0010);
        chk("hold_pdata", bus.pdata, 32'h1122_3344);
        chk("hold_pwrite", 32'(bus.pwrite), 32'd1);

        // req held high through a transfer is not queued
        run(mk(1, 2'd2, 0, 32'h5000_0000, 32'h0BAD_CAFE, 32'h0, 1, 0, 1, 0, 32'h0, 4'b1111, 32'h0BAD_CAFE, 4), 1'b1);

        // Reset asserted in ACCESS of a stalled transfer: no ack, bus released
        @(negedge pclk);
        bus.req       = 1'b1;
        bus.req_addr  = 32'h4000_0000;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd2;
        bus.perr      = 1'b0;
        bus.pready    = 1'b0;
        @(negedge pclk);
        bus.req = 1'b0;
        repeat (2) @(negedge pclk);
        chk("pre_rst_penable", 32'(bus.penable), 32'd1);
        a0    = n_ack;
        reset = 1'b1;
        @(negedge pclk);
        chk("mid_rst_psel", 32'(bus.psel), 32'd0);
        chk("mid_rst_penable", 32'(bus.penable), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge pclk);
        chk("mid_rst_no_ack", 32'(n_ack - a0), 32'd0);

        // Fresh timeout after reset must take the full count again
        tv = mk(0, 2'd2, 0, 32'h4000_0000, 32'h0, 32'h0, 255, 0, 1, 1, 32'h0, 4'b0000, 32'h0, 6);
        run(tv, 1'b0);

        repeat (2) @(negedge pclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
